// File: rtl/inst_loader_pkg.sv
// Shared types and default sizes for the instruction memory loader.
//   state_t : loader FSM states
//   DEF_IW  : default instruction address width (depth = 2**DEF_IW words)
//   DEF_DW  : default machine code word width
package inst_loader_pkg;

  localparam int unsigned DEF_IW = 9;
  localparam int unsigned DEF_DW = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    TRAIL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_ram.sv
// Instruction storage: 2**AW x DW array, one synchronous write port and
// one combinational read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : word at raddr (combinational)
module inst_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fetch port
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// Writable instruction memory filled by a valid/ready word stream starting
// at address 0, with a combinational fetch port for the program counter.
// Optional feature: define LOADER_CHECKSUM_EN to require one XOR trailer
// word after the data words; a mismatching trailer raises load_err.
//   clk, rst     : clock, asynchronous active-high reset
//   load_start   : one-cycle load request; load_len sampled with it
//   load_len     : number of program words (1 .. 2**IW valid)
//   wr_data      : word to store, qualified by wr_valid / wr_ready
//   wr_valid     : wr_data valid
//   wr_ready     : loader accepts a word this cycle
//   inst_address : fetch address
//   inst_out     : memory word at inst_address (combinational)
//   load_busy    : load in progress
//   load_done    : last load finished (sticky until next accepted start)
//   load_err     : bad length or checksum failure
//   word_count   : words written in the current or last load
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [IW:0]   load_len,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] inst_address,
  output logic [DW-1:0] inst_out,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err,
  output logic [IW:0]   word_count
);

  localparam int unsigned DEPTH = 1 << IW;

  state_t      state_q, state_d;
  logic [IW:0] len_q, len_d;
  logic [IW:0] cnt_q, cnt_d;
  logic [IW:0] cnt_inc;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        hs;
  logic        len_ok;
  logic        we;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign hs      = wr_valid & ready_q;
  assign len_ok  = (load_len != '0) && (load_len <= (IW+1)'(DEPTH));
  assign cnt_inc = cnt_q + (IW+1)'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = done_q;
    we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          cnt_d = '0;
          if (len_ok) begin
            len_d   = load_len;
            err_d   = 1'b0;
            done_d  = 1'b0;
            state_d = LOAD;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          we    = 1'b1;
          cnt_d = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ wr_data;
          if (cnt_inc == len_q) state_d = TRAIL;
`else
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      TRAIL: begin
        // Trailer word is compared, never stored
        if (hs) begin
          if (wr_data != csum_q) err_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Moore outputs registered from the next state
    ready_d = (state_d == LOAD) || (state_d == TRAIL);
    busy_d  = ready_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of accepted data words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  inst_ram #(
    .AW (IW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (cnt_q[IW-1:0]),
    .wdata (wr_data),
    .raddr (inst_address),
    .rdata (inst_out)
  );

  assign wr_ready   = ready_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = cnt_q;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writable instruction memory with a sequential load port. Test harnesses and host links use it to stream machine code into the core's instruction store at run time instead of preloading it from a text file. A valid/ready write stream fills consecutive addresses starting at 0. A combinational read port with the same address/data shape as the core's instruction fetch serves the program counter.

## Interface
- IW, 9, instruction address width; memory depth is 2**IW words
- DW, 9, machine code word width
- Clk  in  1  sole clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all control state
- LoadStart  in  1  single-cycle request to begin a load
- LoadLen  in  IW+1  number of program words; sampled with LoadStart
- WrData  in  DW  instruction word to store
- WrValid  in  1  WrData is valid this cycle
- WrReady  out  1  loader accepts WrData this cycle
- InstAddress  in  IW  fetch address from the program counter
- InstOut  out  DW  memory word at InstAddress
- LoadBusy  out  1  load in progress
- LoadDone  out  1  last load completed successfully or with error, sticky until next start
- LoadErr  out  1  bad length or checksum failure
- WordCount  out  IW+1  words written in the current or last load

## Operation
- States: IDLE, LOAD, TRAIL, DONE. Reset value is IDLE.
- IDLE, LoadStart=1, 1 ≤ LoadLen ≤ 2**IW:
  - latch LoadLen
  - WordCount←0, LoadErr←0
  - go to LOAD
- IDLE or DONE, LoadStart=1, bad LoadLen (0 or >2**IW):
  - LoadErr←1, LoadDone←1
  - state goes to or stays in DONE
  - WordCount←0
- LOAD: WrReady=1.
  - A handshake is WrValid&WrReady in the same cycle.
  - On each handshake: mem[WordCount[IW-1:0]]←WrData, WordCount←WordCount+1.
  - The handshake where WordCount+1 equals the latched length ends the load. The next state is TRAIL with checksum enabled, otherwise DONE.
- DONE: LoadDone=1, WrReady=0. LoadStart (valid length) restarts exactly as from IDLE and clears LoadDone.
- LoadStart while in LOAD or TRAIL is ignored. The in-progress load continues unchanged.
- WrValid outside LOAD/TRAIL is ignored and nothing is written.
- The address never wraps. The length check guarantees WordCount ≤ 2**IW, so the maximum length fills exactly addresses 0..2**IW-1.
- InstOut = mem[InstAddress], combinational, in every state. Words not yet written in this load keep their previous contents.
- Memory contents are not affected by Reset. A reset mid-load aborts the load: words already written persist, and all outputs return to reset values.
- Reset values of outputs:
  - WrReady=0, LoadBusy=0, LoadDone=0, LoadErr=0, WordCount=0
  - InstOut follows memory

## Timing
- WrReady and LoadBusy are registered Moore outputs of the state. LoadBusy=1 in LOAD and TRAIL.
- The first WrReady=1 is in the cycle after LoadStart is accepted.
- A write lands on the rising edge of its handshake. InstOut at that address shows the new word from the next cycle on.
- Throughput is one word per cycle while WrValid is held high.
- LoadDone rises in the cycle after the final handshake (the data handshake, or the trailer handshake if checksum is enabled).
- A final handshake and LoadStart in the same cycle: LoadStart is ignored and the load completes normally.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - a running XOR of all accepted data words is kept and cleared on start
  - after the last data word the state is TRAIL, with WrReady=1
  - one trailer word is accepted and not written to memory
  - if the trailer ≠ XOR, LoadErr←1
  - then DONE
- LOADER_CHECKSUM_EN undefined:
  - there is no TRAIL state and no XOR register
  - LOAD goes directly to DONE
  - LoadErr flags bad length only

## Structure
- Package inst_loader_pkg holds:
  - the state enum typedef (IDLE, LOAD, TRAIL, DONE)
  - default IW/DW localparams
- Sub-module inst_ram holds the storage: 2**IW×DW array, one synchronous write port, one combinational read port.
- The top level holds the FSM, the counter, the length latch and the checksum.

## Test plan
- LoadStart with LoadLen=4, then words 0x1A1,0x002,0x1FF,0x055 with WrValid held high. Required: WrReady rises the cycle after start; LoadDone rises the cycle after the 4th handshake; WordCount=4; InstAddress 0..3 read back the words in order.
- Same load, with WrValid toggled 1,0,1,0. Required: only handshake cycles write; the final contents equal the first test.
- LoadLen=0, then LoadLen=513 with IW=9. Required: the cycle after each start, LoadErr=1 and LoadDone=1; WordCount=0; WrReady never 1.
- Assert Reset after 2 of 4 words. Required: all outputs go to 0 immediately; addresses 0–1 hold the new words and addresses 2–3 keep their old contents.
- LoadLen=512 with data = address. Required: LoadDone after 512 handshakes; mem[511]=0x1FF; nothing written past 511; InstAddress 0 still 0x000.
- LOADER_CHECKSUM_EN defined, LoadLen=2, words 0x0F0,0x00F:
  - trailer 0x0FF: LoadErr=0
  - trailer 0x000: LoadErr=1
  - in both cases the trailer is not stored
